// File: rtl/dense_layer_sequencer.sv
// =============================================================================
// dense_layer_sequencer: runs a chain of dense layers on one compute engine,
// requantizing results to int8 and writing them back to tensor RAM.
// Revision: 1.0
// =============================================================================
`default_nettype none

module dense_layer_sequencer #(
    parameter int MAX_LAYERS = 8,
    parameter int MAX_IN     = 256,
    parameter int MAX_OUT    = 64,
    localparam int LW = $clog2(MAX_LAYERS),
    localparam int NW = $clog2(MAX_LAYERS + 1),
    localparam int BW = $clog2(MAX_OUT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [NW-1:0] num_layers,
    output logic [LW-1:0] desc_idx,
    input  logic [8:0]    desc_input_size,
    input  logic [6:0]    desc_output_size,
    input  logic [4:0]    desc_shift,
    input  logic          desc_relu,
    output logic [LW-1:0] layer_sel,
    output logic          dc_start_compute,
    output logic          dc_input_valid,
    output logic [8:0]    dc_input_size,
    output logic [6:0]    dc_output_size,
    input  logic [31:0]   dc_output_data,
    input  logic [5:0]    dc_output_channel,
    input  logic          dc_output_ready,
    input  logic          dc_computation_complete,
    output logic          tram_we,
    output logic [7:0]    tram_waddr,
    output logic [7:0]    tram_wdata,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_SETTLE = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] layer_q, layer_d;
    logic [NW-1:0] num_q, num_d;
    logic [8:0]    in_size_q, in_size_d;
    logic [6:0]    out_size_q, out_size_d;
    logic [4:0]    shift_q, shift_d;
    logic          relu_q, relu_d;
    logic          run_q, run_d;
    logic          seen_q, seen_d;
    logic [6:0]    k_q, k_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [7:0]    buf_q [MAX_OUT];

    logic          desc_bad;
    logic          last_channel;
    logic          last_write;
    logic          last_layer;

    // Round-half-up right shift in 33 bits, optional ReLU, then int8 saturation.
    function automatic logic [7:0] requant(input logic [31:0] acc,
                                           input logic [4:0]  s,
                                           input logic        relu);
        logic signed [32:0] ext;
        logic signed [32:0] sum;
        logic signed [32:0] r;
        ext = {acc[31], acc};
        if (s == 5'd0) begin
            r = ext;
        end else begin
            sum = ext + (33'sd1 <<< (s - 5'd1));
            r   = sum >>> s;
        end
        if (relu && (r < 33'sd0)) begin
            r = 33'sd0;
        end
        if (r > 33'sd127) begin
            return 8'h7f;
        end else if (r < -33'sd128) begin
            return 8'h80;
        end
        return r[7:0];
    endfunction

    assign desc_bad = (desc_input_size == 9'd0) || (desc_input_size > 9'(MAX_IN)) ||
                      (desc_output_size == 7'd0) || (desc_output_size > 7'(MAX_OUT));
    assign last_channel = ({1'b0, dc_output_channel} == (out_size_q - 7'd1));
    assign last_write   = (k_q == (out_size_q - 7'd1));
    assign last_layer   = (NW'(layer_q) == (num_q - NW'(1)));

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        num_d      = num_q;
        in_size_d  = in_size_q;
        out_size_d = out_size_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        seen_d     = seen_q;
        k_d        = k_q;
        done_d     = 1'b0;
        error_d    = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (num_layers != '0) begin
                        state_d = S_FETCH;
                        layer_d = '0;
                        num_d   = num_layers;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                in_size_d  = desc_input_size;
                out_size_d = desc_output_size;
                shift_d    = desc_shift;
                relu_d     = desc_relu;
                if (desc_bad) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                    seen_d  = 1'b0;
                end
            end
            S_RUN: begin
                seen_d = seen_q | dc_computation_complete;
                if (dc_output_ready && last_channel) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave only after the engine's COMPLETE pulse has come and gone.
                if (seen_q && !dc_computation_complete) begin
                    state_d = S_SETTLE;
                end else begin
                    seen_d = seen_q | dc_computation_complete;
                end
            end
            S_SETTLE: begin
                state_d = S_WB;
                k_d     = 7'd0;
            end
            S_WB: begin
                if (last_write) begin
                    if (last_layer) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        layer_d = layer_q + LW'(1);
                    end
                end else begin
                    k_d = k_q + 7'd1;
                end
            end
            S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        run_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            layer_q    <= '0;
            num_q      <= '0;
            in_size_q  <= '0;
            out_size_q <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            run_q      <= 1'b0;
            seen_q     <= 1'b0;
            k_q        <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            num_q      <= num_d;
            in_size_q  <= in_size_d;
            out_size_q <= out_size_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            run_q      <= run_d;
            seen_q     <= seen_d;
            k_q        <= k_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == S_RUN) && dc_output_ready) begin
            buf_q[dc_output_channel[BW-1:0]] <= requant(dc_output_data, shift_q, relu_q);
        end
    end

    assign desc_idx         = layer_q;
    assign layer_sel        = layer_q;
    assign dc_start_compute = run_q;
    assign dc_input_valid   = run_q;
    assign dc_input_size    = in_size_q;
    assign dc_output_size   = out_size_q;
    assign tram_we          = (state_q == S_WB);
    assign tram_waddr       = tram_we ? {1'b0, k_q} : 8'd0;
    assign tram_wdata       = tram_we ? buf_q[k_q[BW-1:0]] : 8'd0;
    assign busy             = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign done             = done_q;
    assign error            = error_q;

endmodule

`default_nettype wire

// File: tb/tb_dense_layer_sequencer.sv
// =============================================================================
// tb_dense_layer_sequencer: engine model + int8 reference scoreboard for the
// dense layer sequencer. Revision: 1.0
// =============================================================================
`default_nettype none

module tb_dense_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  num_layers = 4'd0;
    logic [2:0]  desc_idx;
    logic [8:0]  desc_input_size;
    logic [6:0]  desc_output_size;
    logic [4:0]  desc_shift;
    logic        desc_relu;
    logic [2:0]  layer_sel;
    logic        dc_start_compute;
    logic        dc_input_valid;
    logic [8:0]  dc_input_size;
    logic [6:0]  dc_output_size;
    logic [31:0] dc_output_data = 32'd0;
    logic [5:0]  dc_output_channel = 6'd0;
    logic        dc_output_ready = 1'b0;
    logic        dc_computation_complete = 1'b0;
    logic        tram_we;
    logic [7:0]  tram_waddr;
    logic [7:0]  tram_wdata;
    logic        busy;
    logic        done;
    logic        error;

    logic [8:0]  d_in   [8];
    logic [6:0]  d_out  [8];
    logic [4:0]  d_sh   [8];
    logic        d_relu [8];

    assign desc_input_size  = d_in[desc_idx];
    assign desc_output_size = d_out[desc_idx];
    assign desc_shift       = d_sh[desc_idx];
    assign desc_relu        = d_relu[desc_idx];

    dense_layer_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .num_layers(num_layers),
        .desc_idx(desc_idx), .desc_input_size(desc_input_size),
        .desc_output_size(desc_output_size), .desc_shift(desc_shift),
        .desc_relu(desc_relu), .layer_sel(layer_sel),
        .dc_start_compute(dc_start_compute), .dc_input_valid(dc_input_valid),
        .dc_input_size(dc_input_size), .dc_output_size(dc_output_size),
        .dc_output_data(dc_output_data), .dc_output_channel(dc_output_channel),
        .dc_output_ready(dc_output_ready),
        .dc_computation_complete(dc_computation_complete),
        .tram_we(tram_we), .tram_waddr(tram_waddr), .tram_wdata(tram_wdata),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int eng_starts = 0;
    int snap_done = 0;
    int snap_starts = 0;
    logic [15:0] exp_q [$];
    logic [15:0] log_q [$];
    logic [31:0] force_q [$];
    int          eng_lsel [$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: floor((acc + 2^(s-1)) / 2^s), ReLU, clamp to int8.
    function automatic logic [7:0] ref_q(input logic [31:0] acc, input int s, input bit relu);
        longint v;
        v = longint'($signed(acc));
        if (s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic logic [31:0] next_data();
        if (force_q.size() != 0) return force_q.pop_front();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 4000)) - 32'd2000;
            2:       return ($urandom_range(0, 1) != 0) ? 32'h7fffffff : 32'h80000000;
            default: return 32'($urandom_range(0, 300));
        endcase
    endfunction

    task automatic emit(input int ch, input logic [31:0] val);
        dc_output_ready   = 1'b1;
        dc_output_channel = 6'(ch);
        dc_output_data    = val;
        @(negedge clk);
        dc_output_ready   = 1'b0;
    endtask

    task automatic run_engine();
        int n;
        int lay;
        logic [31:0] vals [64];
        n   = int'(dc_output_size);
        lay = int'(layer_sel);
        eng_starts++;
        eng_lsel.push_back(lay);
        chk_eq("eng_valid", 32'(dc_input_valid), 32'd1);
        chk_eq("eng_in_size", 32'(dc_input_size), 32'(d_in[lay]));
        for (int ch = 0; ch < n; ch++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (ch == n - 1 && n > 1 && force_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                vals[0] = next_data();
                emit(0, vals[0]);
            end
            vals[ch] = next_data();
            emit(ch, vals[ch]);
            chk_eq((ch == n - 1) ? "start_fall" : "start_held", 32'(dc_start_compute),
                   (ch == n - 1) ? 32'd0 : 32'd1);
        end
        for (int k = 0; k < n; k++)
            exp_q.push_back({8'(k), ref_q(vals[k], int'(d_sh[lay]), d_relu[lay])});
        dc_computation_complete = 1'b1;
        @(negedge clk);
        chk_eq("no_restart", 32'(dc_start_compute), 32'd0);
        @(negedge clk);
        dc_computation_complete = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (dc_start_compute && !reset) run_engine();
        end
    end

    always @(negedge clk) begin
        if (tram_we) begin
            logic [15:0] e;
            log_q.push_back({tram_waddr, tram_wdata});
            chk_eq("wr_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk_eq("wr_addr", 32'(tram_waddr), 32'(e[15:8]));
                chk_eq("wr_data", 32'(tram_wdata), 32'(e[7:0]));
            end
            chk_eq("we_vs_start", 32'(dc_start_compute), 32'd0);
        end
        if (done) done_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic kick(input int num);
        snap_done   = done_cnt;
        snap_starts = eng_starts;
        log_q.delete();
        eng_lsel.delete();
        @(negedge clk);
        num_layers = 4'(num);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk_eq("idle_timeout", 32'(t < 5000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic finish_run(input string tag, input int exp_err, input int exp_done,
                              input int exp_starts);
        chk_eq({tag, "_error"}, 32'(error), 32'(exp_err));
        chk_eq({tag, "_done"}, 32'(done_cnt - snap_done), 32'(exp_done));
        chk_eq({tag, "_starts"}, 32'(eng_starts - snap_starts), 32'(exp_starts));
        chk_eq({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
        chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic set_desc(input int l, input int i, input int o, input int s, input bit r);
        d_in[l]   = 9'(i);
        d_out[l]  = 7'(o);
        d_sh[l]   = 5'(s);
        d_relu[l] = r;
    endtask

    initial begin
        int t;
        int nl;
        int first_bad;
        int nwr;
        for (int l = 0; l < 8; l++) set_desc(l, 1, 1, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_error", 32'(error), 32'd0);
        chk_eq("rst_start", 32'(dc_start_compute), 32'd0);
        chk_eq("rst_valid", 32'(dc_input_valid), 32'd0);
        chk_eq("rst_we", 32'(tram_we), 32'd0);
        chk_eq("rst_layer", 32'(layer_sel), 32'd0);
        chk_eq("rst_osize", 32'(dc_output_size), 32'd0);
        reset = 1'b0;

        // Single layer with saturating negative result
        set_desc(0, 4, 2, 0, 1'b0);
        force_q.push_back(32'd100);
        force_q.push_back(-32'sd300);
        kick(1);
        wait_idle();
        finish_run("t1", 0, 1, 1);
        chk_eq("t1_nwr", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            chk_eq("t1_w0", 32'(log_q[0]), 32'h0064);
            chk_eq("t1_w1", 32'(log_q[1]), 32'h0180);
        end

        // Requant corner values, one channel per layer
        set_desc(0, 4, 1, 4, 1'b0);
        set_desc(1, 1, 1, 3, 1'b1);
        set_desc(2, 1, 1, 0, 1'b0);
        force_q.push_back(32'h00000181);
        force_q.push_back(-32'sd40);
        force_q.push_back(32'h7fffffff);
        kick(3);
        wait_idle();
        finish_run("t2", 0, 1, 3);
        chk_eq("t2_nwr", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk_eq("t2_q24", 32'(log_q[0][7:0]), 32'd24);
            chk_eq("t2_relu", 32'(log_q[1][7:0]), 32'd0);
            chk_eq("t2_sat", 32'(log_q[2][7:0]), 32'd127);
        end

        // Three chained layers
        set_desc(0, 16, 8, 5, 1'b0);
        set_desc(1, 8, 4, 2, 1'b1);
        set_desc(2, 4, 1, 9, 1'b0);
        kick(3);
        wait_idle();
        finish_run("t3", 0, 1, 3);
        chk_eq("t3_nwr", 32'(log_q.size()), 32'd13);
        chk_eq("t3_nsel", 32'(eng_lsel.size()), 32'd3);
        for (int i = 0; i < eng_lsel.size(); i++) chk_eq("t3_sel", 32'(eng_lsel[i]), 32'(i));

        // Bad descriptor on second layer
        set_desc(0, 10, 3, 1, 1'b0);
        set_desc(1, 10, 65, 1, 1'b0);
        kick(2);
        wait_idle();
        finish_run("t4", 1, 0, 1);
        chk_eq("t4_nwr", 32'(log_q.size()), 32'd3);

        // Reset in the middle of writeback
        set_desc(0, 8, 8, 0, 1'b0);
        kick(1);
        chk_eq("t5_errclr", 32'(error), 32'd0);
        t = 0;
        while (!(tram_we && tram_waddr == 8'd3) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk_eq("t5_reach", 32'(t < 2000), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_eq("t5_we", 32'(tram_we), 32'd0);
        chk_eq("t5_busy", 32'(busy), 32'd0);
        chk_eq("t5_nwr", 32'(log_q.size()), 32'd4);
        exp_q.delete();
        repeat (4) @(negedge clk);
        chk_eq("t5_quiet", 32'(log_q.size()), 32'd4);
        kick(1);
        wait_idle();
        finish_run("t5b", 0, 1, 1);
        chk_eq("t5b_nwr", 32'(log_q.size()), 32'd8);

        // Start while busy is ignored; zero-layer start only pulses done
        set_desc(0, 4, 4, 2, 1'b0);
        kick(1);
        t = 0;
        while (!dc_start_compute && t < 100) begin
            @(negedge clk);
            t++;
        end
        num_layers = 4'd0;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        chk_eq("t6_busy", 32'(busy), 32'd1);
        wait_idle();
        finish_run("t6", 0, 1, 1);
        kick(0);
        wait_idle();
        finish_run("t6z", 0, 1, 0);

        // Randomized layer chains, occasionally with an invalid descriptor
        for (int r = 0; r < 10; r++) begin
            nl        = $urandom_range(1, 4);
            first_bad = nl;
            nwr       = 0;
            for (int l = 0; l < nl; l++) begin
                set_desc(l, $urandom_range(1, 256), $urandom_range(1, 12),
                         $urandom_range(0, 31), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       d_in[l]  = 9'd0;
                        1:       d_in[l]  = 9'($urandom_range(257, 511));
                        2:       d_out[l] = 7'd0;
                        default: d_out[l] = 7'($urandom_range(65, 127));
                    endcase
                    if (first_bad == nl) first_bad = l;
                end
                if (first_bad == nl) nwr += int'(d_out[l]);
            end
            kick(nl);
            wait_idle();
            finish_run("rnd", (first_bad < nl) ? 1 : 0, (first_bad < nl) ? 0 : 1, first_bad);
            chk_eq("rnd_nwr", 32'(log_q.size()), 32'(nwr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
